// File: rtl/lcd_pixel_src_if.sv
// Pixel-request, camera-FIFO and bounding-box handshake bundle for lcd_pixel_src.
// The slave modport is the pixel source; the master modport is its surrounding logic.
interface lcd_pixel_src_if;
  logic        data_req;
  logic [10:0] pixel_xpos;
  logic [10:0] pixel_ypos;
  logic        out_vsync;
  logic        fifo_rd_en;
  logic [15:0] fifo_rdata;
  logic        fifo_empty;
  logic [10:0] box_x0;
  logic [10:0] box_y0;
  logic [10:0] box_x1;
  logic [10:0] box_y1;
  logic        box_valid;
  logic        box_ready;
  logic [15:0] pixel_data;
  logic        underflow;
  logic [15:0] frame_cnt;

  modport slave (
    input  data_req, pixel_xpos, pixel_ypos, out_vsync,
    input  fifo_rdata, fifo_empty,
    input  box_x0, box_y0, box_x1, box_y1, box_valid,
    output fifo_rd_en, box_ready, pixel_data, underflow, frame_cnt
  );

  modport master (
    output data_req, pixel_xpos, pixel_ypos, out_vsync,
    output fifo_rdata, fifo_empty,
    output box_x0, box_y0, box_x1, box_y1, box_valid,
    input  fifo_rd_en, box_ready, pixel_data, underflow, frame_cnt
  );
endinterface

// File: rtl/lcd_pixel_src.sv
// LCD pixel source: streams camera FIFO pixels to the LCD and overlays a bounding-box border.
// New boxes are shadowed and only promoted at frame start so a frame never shows a torn box.
module lcd_pixel_src #(
  parameter logic [15:0] BOX_COLOR = 16'hF800,
  parameter logic [15:0] BG_COLOR  = 16'h0000,
  parameter int unsigned BORDER_W  = 2
) (
  input  logic           lcd_clk,
  input  logic           sys_rst_n,
  lcd_pixel_src_if.slave bus
);

  // 12-bit compare width keeps coordinate + border sums from wrapping
  localparam int unsigned CW = 12;

  typedef struct packed {
    logic [10:0] x0;
    logic [10:0] y0;
    logic [10:0] x1;
    logic [10:0] y1;
  } box_t;

  typedef enum logic {IDLE, PENDING} state_t;

  state_t      state_q, state_nxt;
  logic        box_ready_q, box_ready_nxt;
  logic        shadow_ld_c, promote_c;
  box_t        shadow_q, active_q;
  logic        box_en_q;

  logic        vsync_q;
  logic        vs_rise_c;
  logic [15:0] frame_cnt_q;
  logic        underflow_q;

  logic        req_d, miss_d, hit_d;
  logic        hit_c;

  logic [CW-1:0] x_c, y_c, bw_c;
  logic [CW-1:0] bx0_c, by0_c, bx1_c, by1_c;
  logic          inside_c, edge_c;

  assign vs_rise_c = bus.out_vsync & ~vsync_q;

  // FIFO pop goes straight out so the word arrives in the following cycle
  assign bus.fifo_rd_en = bus.data_req & ~bus.fifo_empty;

  // Border hit for the requested pixel; LCD rows are 1-based, box rows 0-based
  assign x_c   = CW'(bus.pixel_xpos);
  assign y_c   = CW'(bus.pixel_ypos) - CW'(1);
  assign bw_c  = CW'(BORDER_W);
  assign bx0_c = CW'(active_q.x0);
  assign by0_c = CW'(active_q.y0);
  assign bx1_c = CW'(active_q.x1);
  assign by1_c = CW'(active_q.y1);

  assign inside_c = box_en_q && (bx0_c <= x_c) && (x_c <= bx1_c)
                             && (by0_c <= y_c) && (y_c <= by1_c);
  assign edge_c   = (x_c < bx0_c + bw_c) || (x_c + bw_c > bx1_c) ||
                    (y_c < by0_c + bw_c) || (y_c + bw_c > by1_c);
  assign hit_c    = inside_c && edge_c;

  // Border wins over underflow so the box stays visible when the FIFO starves
  assign bus.pixel_data = !req_d ? 16'h0000   :
                          hit_d  ? BOX_COLOR  :
                          miss_d ? BG_COLOR   :
                                   bus.fifo_rdata;

  assign bus.box_ready = box_ready_q;
  assign bus.underflow = underflow_q;
  assign bus.frame_cnt = frame_cnt_q;

  // Box handshake next-state logic
  always_comb begin
    state_nxt     = state_q;
    box_ready_nxt = box_ready_q;
    shadow_ld_c   = 1'b0;
    promote_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.box_valid) begin
          shadow_ld_c   = 1'b1;
          state_nxt     = PENDING;
          box_ready_nxt = 1'b0;
        end
      end
      PENDING: begin
        if (vs_rise_c) begin
          promote_c     = 1'b1;
          state_nxt     = IDLE;
          box_ready_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt     = IDLE;
        box_ready_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      box_ready_q <= 1'b1;
    end else begin
      state_q     <= state_nxt;
      box_ready_q <= box_ready_nxt;
    end
  end

  // Shadow capture and frame-aligned promotion of the active box
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      box_en_q <= 1'b0;
    end else begin
      if (shadow_ld_c) begin
        shadow_q <= '{x0: bus.box_x0, y0: bus.box_y0, x1: bus.box_x1, y1: bus.box_y1};
      end
      if (promote_c) begin
        active_q <= shadow_q;
        box_en_q <= 1'b1;
      end
    end
  end

  // Frame-start edge detect, frame counter and sticky underflow flag
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vsync_q     <= 1'b0;
      frame_cnt_q <= '0;
      underflow_q <= 1'b0;
    end else begin
      vsync_q <= bus.out_vsync;
      if (vs_rise_c) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (bus.data_req && bus.fifo_empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // Per-request qualifiers aligned with the FIFO read data
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      req_d  <= 1'b0;
      miss_d <= 1'b0;
      hit_d  <= 1'b0;
    end else begin
      req_d  <= bus.data_req;
      miss_d <= bus.data_req & bus.fifo_empty;
      hit_d  <= bus.data_req & hit_c;
    end
  end

endmodule

// File: tb/tb_lcd_pixel_src.sv
// Directed bench for lcd_pixel_src: expected pixels queued at request time, compared a cycle later.
module tb_lcd_pixel_src;

  localparam logic [15:0] BOX = 16'hF800;
  localparam logic [15:0] BG  = 16'h001F;
  localparam logic [15:0] STALE = 16'hBEEF;

  logic lcd_clk = 1'b0;
  logic sys_rst_n;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_frames = 16'd0;
  logic [15:0] sb[$];

  lcd_pixel_src_if bus ();

  lcd_pixel_src #(
    .BOX_COLOR(BOX),
    .BG_COLOR (BG),
    .BORDER_W (2)
  ) dut (
    .lcd_clk  (lcd_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus.slave)
  );

  always #5 lcd_clk = ~lcd_clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One pixel cycle: drive request, model the FIFO read, compare the pixel one cycle later
  task automatic tick(input string tag, input logic req, input int x, input int yp,
                      input logic empty, input logic [15:0] data, input logic [15:0] exp);
    logic rd;
    logic [15:0] want;
    bus.data_req   = req;
    bus.pixel_xpos = 11'(x);
    bus.pixel_ypos = 11'(yp);
    bus.fifo_empty = empty;
    sb.push_back(exp);
    #1;
    rd = bus.fifo_rd_en;
    if (req) check({tag, "_rd_en"}, 16'(rd), 16'(!empty));
    @(posedge lcd_clk);
    #1;
    bus.fifo_rdata = rd ? data : STALE;
    bus.data_req   = 1'b0;
    #1;
    want = sb.pop_front();
    check(tag, bus.pixel_data, want);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick("idle", 1'b0, 0, 0, 1'b0, 16'h0000, 16'h0000);
  endtask

  // Pixel at 0-based row y; LCD row index is y+1
  task automatic pix(input string tag, input int x, input int y, input logic [15:0] exp_or_data,
                     input logic border);
    logic [15:0] d;
    d = 16'h0100 + 16'(x);
    tick(tag, 1'b1, x, y + 1, 1'b0, d, border ? exp_or_data : d);
  endtask

  task automatic vsync_pulse(input int n);
    bus.out_vsync = 1'b1;
    idle(n);
    bus.out_vsync = 1'b0;
    idle(1);
    exp_frames = exp_frames + 16'd1;
    check("frame_cnt", bus.frame_cnt, exp_frames);
  endtask

  task automatic load_box(input int x0, input int y0, input int x1, input int y1);
    check("box_ready_pre", 16'(bus.box_ready), 16'd1);
    bus.box_x0 = 11'(x0); bus.box_y0 = 11'(y0);
    bus.box_x1 = 11'(x1); bus.box_y1 = 11'(y1);
    bus.box_valid = 1'b1;
    idle(1);
    bus.box_valid = 1'b0;
    check("box_ready_pend", 16'(bus.box_ready), 16'd0);
  endtask

  initial begin
    sys_rst_n      = 1'b0;
    bus.data_req   = 1'b1;
    bus.pixel_xpos = '0;
    bus.pixel_ypos = '0;
    bus.out_vsync  = 1'b0;
    bus.fifo_rdata = STALE;
    bus.fifo_empty = 1'b0;
    bus.box_x0 = '0; bus.box_y0 = '0; bus.box_x1 = '0; bus.box_y1 = '0;
    bus.box_valid  = 1'b0;

    // Reset state; FIFO pop still follows request during reset
    #1;
    check("rst_rd_en", 16'(bus.fifo_rd_en), 16'd1);
    repeat (3) @(posedge lcd_clk);
    #1;
    check("rst_pixel", bus.pixel_data, 16'h0000);
    check("rst_underflow", 16'(bus.underflow), 16'd0);
    check("rst_frame_cnt", bus.frame_cnt, 16'h0000);
    check("rst_box_ready", 16'(bus.box_ready), 16'd1);
    bus.data_req = 1'b0;
    sys_rst_n = 1'b1;
    idle(2);

    // Passthrough burst with no box
    for (int x = 0; x < 480; x++) tick("pass", 1'b1, x, 1, 1'b0, 16'h1234, 16'h1234);
    idle(3);
    check("pass_underflow", 16'(bus.underflow), 16'd0);

    // Long vsync counts once
    vsync_pulse(100);

    // Box draw after promotion
    load_box(10, 20, 50, 40);
    pix("pre_promote", 10, 25, 16'h0, 1'b0);
    vsync_pulse(3);
    check("box_ready_back", 16'(bus.box_ready), 16'd1);
    pix("b_10_25", 10, 25, BOX, 1'b1);
    pix("b_11_25", 11, 25, BOX, 1'b1);
    pix("b_12_25", 12, 25, 16'h0, 1'b0);
    pix("b_49_30", 49, 30, BOX, 1'b1);
    pix("b_30_21", 30, 21, BOX, 1'b1);
    pix("b_30_22", 30, 22, 16'h0, 1'b0);
    pix("b_51_25", 51, 25, 16'h0, 1'b0);
    pix("b_50_40", 50, 40, BOX, 1'b1);
    pix("b_30_20", 30, 20, BOX, 1'b1);
    pix("b_9_25", 9, 25, 16'h0, 1'b0);
    pix("b_30_39", 30, 39, BOX, 1'b1);
    pix("b_30_38", 30, 38, 16'h0, 1'b0);
    pix("b_30_41", 30, 41, 16'h0, 1'b0);
    pix("b_30_19", 30, 19, 16'h0, 1'b0);

    // Mid-frame handshake: old box persists, offers in PENDING are ignored
    load_box(100, 100, 120, 110);
    pix("hs_old", 10, 25, BOX, 1'b1);
    pix("hs_new_early", 100, 105, 16'h0, 1'b0);
    bus.box_x0 = 11'd300; bus.box_y0 = 11'd300; bus.box_x1 = 11'd320; bus.box_y1 = 11'd320;
    bus.box_valid = 1'b1;
    idle(2);
    bus.box_valid = 1'b0;
    check("hs_pend_ready", 16'(bus.box_ready), 16'd0);
    vsync_pulse(2);
    check("hs_ready_back", 16'(bus.box_ready), 16'd1);
    pix("hs_new", 100, 105, BOX, 1'b1);
    pix("hs_old_gone", 10, 25, 16'h0, 1'b0);
    pix("hs_ignored", 300, 305, 16'h0, 1'b0);

    // Box accepted on the vs_rise cycle waits for the following frame
    bus.box_x0 = 11'd200; bus.box_y0 = 11'd200; bus.box_x1 = 11'd210; bus.box_y1 = 11'd210;
    bus.box_valid = 1'b1;
    bus.out_vsync = 1'b1;
    idle(1);
    bus.box_valid = 1'b0;
    idle(3);
    bus.out_vsync = 1'b0;
    idle(1);
    exp_frames = exp_frames + 16'd1;
    check("same_frame_cnt", bus.frame_cnt, exp_frames);
    check("same_pend", 16'(bus.box_ready), 16'd0);
    pix("same_keep", 100, 105, BOX, 1'b1);
    pix("same_wait", 200, 205, 16'h0, 1'b0);
    vsync_pulse(2);
    pix("same_promoted", 200, 205, BOX, 1'b1);

    // Underflow: background substitution, sticky flag, border still wins
    tick("uf_x5", 1'b1, 5, 1, 1'b1, 16'h5555, BG);
    check("uf_set", 16'(bus.underflow), 16'd1);
    tick("uf_border", 1'b1, 200, 206, 1'b1, 16'h5555, BOX);
    tick("uf_recover", 1'b1, 6, 1, 1'b0, 16'h6666, 16'h6666);
    idle(2);
    check("uf_sticky", 16'(bus.underflow), 16'd1);

    // Inverted box never draws
    load_box(60, 20, 40, 40);
    vsync_pulse(2);
    pix("inv_50", 50, 25, 16'h0, 1'b0);
    pix("inv_60", 60, 25, 16'h0, 1'b0);
    pix("inv_40", 40, 25, 16'h0, 1'b0);
    pix("inv_60_20", 60, 20, 16'h0, 1'b0);

    // Frame counter wrap
    force dut.frame_cnt_q = 16'hFFFE;
    idle(1);
    release dut.frame_cnt_q;
    idle(1);
    exp_frames = 16'hFFFE;
    vsync_pulse(1);
    vsync_pulse(1);

    // Reset while a box is pending and a request is in flight
    load_box(300, 300, 310, 310);
    bus.data_req = 1'b1;
    bus.fifo_empty = 1'b0;
    @(posedge lcd_clk);
    #3;
    sys_rst_n = 1'b0;
    #1;
    check("mid_rst_pixel", bus.pixel_data, 16'h0000);
    check("mid_rst_ready", 16'(bus.box_ready), 16'd1);
    check("mid_rst_uf", 16'(bus.underflow), 16'd0);
    bus.data_req = 1'b0;
    @(posedge lcd_clk);
    #1;
    sys_rst_n = 1'b1;
    idle(1);
    exp_frames = 16'd0;
    vsync_pulse(2);
    pix("rst_dropped", 300, 305, 16'h0, 1'b0);
    pix("rst_box_en", 60, 25, 16'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
